// File: rtl/parity_frame_tx_ctrl.sv
// Serial transmit controller: frames a data word with its even-parity bit as the LSB
// and shifts the WIDTH+1 bit frame out MSB first, each bit held CLK_DIV cycles.
module parity_frame_tx_ctrl #(
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             tx_bit,
  output logic             tx_active,
  output logic             bit_strobe,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int FW     = WIDTH + 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BITS_W = $clog2(FW + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BITS_W-1:0] BITS_INIT = BITS_W'(FW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [FW-1:0]       shreg, shreg_n;
  logic [BITS_W-1:0]   bits_left, bits_left_n;
  logic [DIV_W-1:0]    div, div_n;
  logic [CNT_W-1:0]    frame_cnt_n;

  // Even parity: the appended LSB makes the frame's count of ones even.
  function automatic logic [FW-1:0] build_frame(input logic [WIDTH-1:0] d);
    return {d, ^d};
  endfunction

  assign in_ready = (state == IDLE);

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bits_left_n = bits_left;
    div_n       = div;
    frame_cnt_n = frame_cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          shreg_n     = build_frame(in_data);
          bits_left_n = BITS_INIT;
          div_n       = '0;
          state_n     = SHIFT;
        end
      end
      SHIFT: begin
        // Abort wins over the bit-period bookkeeping on the same edge.
        if (abort) begin
          state_n     = IDLE;
          shreg_n     = '0;
          bits_left_n = '0;
          div_n       = '0;
        end else if (div == DIV_LAST) begin
          shreg_n     = {shreg[FW-2:0], 1'b0};
          bits_left_n = bits_left - BITS_W'(1);
          div_n       = '0;
          if (bits_left == BITS_W'(1)) begin
            state_n     = DONE;
            frame_cnt_n = frame_cnt + CNT_W'(1);
          end
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register; outputs are registered from the next-state view so they line up
  // with the state they describe.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state      <= IDLE;
      shreg      <= '0;
      bits_left  <= '0;
      div        <= '0;
      frame_cnt  <= '0;
      tx_bit     <= 1'b0;
      tx_active  <= 1'b0;
      bit_strobe <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bits_left  <= bits_left_n;
      div        <= div_n;
      frame_cnt  <= frame_cnt_n;
      tx_active  <= (state_n == SHIFT);
      tx_bit     <= (state_n == SHIFT) && shreg_n[FW-1];
      bit_strobe <= (state_n == SHIFT) && (div_n == '0);
      frame_done <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_parity_frame_tx_ctrl.sv
// Bench for parity_frame_tx_ctrl: table vectors, abort/reset/wrap sequences and
// random words checked against a bit-counting reference model.
module tb_parity_frame_tx_ctrl;
  localparam int WIDTH   = 8;
  localparam int CLK_DIV = 2;
  localparam int CNT_W   = 4;
  localparam int NCYC    = (WIDTH + 1) * CLK_DIV;

  logic             clk = 1'b0;
  logic             reset_p;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             abort;
  logic             tx_bit;
  logic             tx_active;
  logic             bit_strobe;
  logic             frame_done;
  logic [CNT_W-1:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fd_total = 0;
  logic [CNT_W-1:0] exp_cnt;

  parity_frame_tx_ctrl #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_p(reset_p), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .tx_bit(tx_bit), .tx_active(tx_active),
    .bit_strobe(bit_strobe), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic [8:0] frame;
    bit         keep;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: count the ones and append a bit that makes the total even.
  function automatic logic [8:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {d, (ones % 2) == 1};
  endfunction

  // Present a word and return at the middle of the first SHIFT cycle.
  task automatic do_accept(input logic [7:0] d, input bit keep, output int acc);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    acc = cyc;
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  // Observe the full frame, the DONE cycle and the return of in_ready.
  task automatic check_frame(input logic [8:0] frame, input bit abort_in_done);
    logic [NCYC-1:0] cap_bits, cap_stb, exp_bits, exp_stb;
    int act_cnt = 0;
    int fd_early = 0;
    for (int t = 0; t < NCYC; t++) begin
      cap_bits[NCYC-1-t] = tx_bit;
      cap_stb[NCYC-1-t]  = bit_strobe;
      exp_bits[NCYC-1-t] = frame[8 - t / CLK_DIV];
      exp_stb[NCYC-1-t]  = (t % CLK_DIV) == 0;
      if (tx_active) act_cnt++;
      if (frame_done) fd_early++;
      @(negedge clk);
    end
    check("frame_bits", 32'(cap_bits), 32'(exp_bits));
    check("strobes", 32'(cap_stb), 32'(exp_stb));
    check("active_cycles", 32'(act_cnt), 32'(NCYC));
    check("no_early_done", 32'(fd_early), 32'd0);
    check("done_pulse", 32'(frame_done), 32'd1);
    check("done_inactive", 32'(tx_active), 32'd0);
    check("done_not_ready", 32'(in_ready), 32'd0);
    if (frame_done) fd_total++;
    if (abort_in_done) abort = 1'b1;
    @(negedge clk);
    abort   = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    check("done_single", 32'(frame_done), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
    check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int acc, prev_acc, fd_seen, fd_start;
    bit prev_keep, wrapped;
    logic [CNT_W-1:0] last_cnt;
    logic [7:0] d;

    reset_p  = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    abort    = 1'b0;
    exp_cnt  = '0;
    vecs[0] = '{8'hA5, 9'h14A, 1'b0};
    vecs[1] = '{8'h07, 9'h00F, 1'b0};
    vecs[2] = '{8'hFF, 9'h1FE, 1'b1};
    vecs[3] = '{8'h01, 9'h003, 1'b0};
    vecs[4] = '{8'h3C, 9'h078, 1'b0};

    #12;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_active", 32'(tx_active), 32'd0);
    check("rst_bit", 32'(tx_bit), 32'd0);
    check("rst_strobe", 32'(bit_strobe), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    reset_p = 1'b0;
    @(negedge clk);

    prev_keep = 1'b0;
    prev_acc  = 0;
    for (int i = 0; i < 4; i++) begin
      do_accept(vecs[i].data, vecs[i].keep, acc);
      if (prev_keep) check("b2b_spacing", 32'(acc - prev_acc), 32'(NCYC + 2));
      check_frame(vecs[i].frame, 1'b0);
      prev_keep = vecs[i].keep;
      prev_acc  = acc;
    end

    // Abort on the 7th SHIFT cycle.
    do_accept(8'h5A, 1'b0, acc);
    repeat (6) @(negedge clk);
    check("pre_abort_active", 32'(tx_active), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_inactive", 32'(tx_active), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_bit", 32'(tx_bit), 32'd0);
    fd_seen = 0;
    repeat (25) begin
      if (frame_done) fd_seen++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(fd_seen), 32'd0);
    check("abort_cnt", 32'(frame_cnt), 32'(exp_cnt));
    do_accept(8'hC3, 1'b0, acc);
    check_frame(model_frame(8'hC3), 1'b0);

    // Abort while idle does not block acceptance; abort during DONE is ignored.
    abort = 1'b1;
    do_accept(8'h96, 1'b0, acc);
    abort = 1'b0;
    check_frame(model_frame(8'h96), 1'b1);

    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      do_accept(d, 1'b0, acc);
      check_frame(model_frame(d), 1'($urandom));
    end

    // Asynchronous reset in the middle of a frame.
    do_accept(8'hE7, 1'b0, acc);
    repeat (4) @(negedge clk);
    #2 reset_p = 1'b1;
    #1;
    check("mid_rst_active", 32'(tx_active), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_bit", 32'(tx_bit), 32'd0);
    check("mid_rst_strobe", 32'(bit_strobe), 32'd0);
    check("mid_rst_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    #3 reset_p = 1'b0;
    @(negedge clk);
    exp_cnt = '0;
    do_accept(vecs[4].data, vecs[4].keep, acc);
    check_frame(vecs[4].frame, 1'b0);

    // Counter wrap over 16 further frames.
    wrapped  = 1'b0;
    fd_start = fd_total;
    last_cnt = frame_cnt;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      do_accept(d, 1'b0, acc);
      check_frame(model_frame(d), 1'b0);
      if (last_cnt == 4'd15 && frame_cnt == 4'd0) wrapped = 1'b1;
      last_cnt = frame_cnt;
    end
    check("wrap_seen", 32'(wrapped), 32'd1);
    check("wrap_done_pulses", 32'(fd_total - fd_start), 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
